// File: rtl/demultiplexer_1_to_16_reg.sv
`default_nettype none
// ============================================================================
// Module   : demultiplexer_1_to_16_reg
// Purpose  : Registered 1-to-16 demultiplexer. Steers one n-bit word per cycle
//            into one of sixteen holding registers, addressed either by an
//            explicit select or by an internal auto-incrementing pointer.
//            Per-slot valid flags, a full flag and a wrap pulse let downstream
//            logic consume a complete 16-word frame.
// Ports    : clk    - system clock, rising edge
//            rst    - asynchronous active-high reset
//            d      - data word to store
//            s      - explicit destination slot (auto=0)
//            load   - write strobe
//            auto   - 1: destination is ptr, 0: destination is s
//            clear  - synchronous frame clear (valid flags, pointer, wrap)
//            y0..15 - holding registers
//            valid  - per-slot written-since-clear flags
//            ptr    - auto-mode write pointer
//            full   - all sixteen slots valid
//            wrap   - one-cycle pulse after an auto write into slot 15
// Revision : 1.0 - initial release
// ============================================================================
module demultiplexer_1_to_16_reg #(
    parameter int n = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [n-1:0]  d,
    input  logic [3:0]    s,
    input  logic          load,
    input  logic          auto,
    input  logic          clear,
    output logic [n-1:0]  y0,
    output logic [n-1:0]  y1,
    output logic [n-1:0]  y2,
    output logic [n-1:0]  y3,
    output logic [n-1:0]  y4,
    output logic [n-1:0]  y5,
    output logic [n-1:0]  y6,
    output logic [n-1:0]  y7,
    output logic [n-1:0]  y8,
    output logic [n-1:0]  y9,
    output logic [n-1:0]  y10,
    output logic [n-1:0]  y11,
    output logic [n-1:0]  y12,
    output logic [n-1:0]  y13,
    output logic [n-1:0]  y14,
    output logic [n-1:0]  y15,
    output logic [15:0]   valid,
    output logic [3:0]    ptr,
    output logic          full,
    output logic          wrap
);

    localparam logic [3:0] c_last_slot = 4'd15;

    logic [n-1:0] r_slot [16];
    logic [15:0]  r_valid;
    logic [3:0]   r_ptr;
    logic         r_wrap;

    logic [3:0]   w_dest;
    logic         w_write;
    logic [15:0]  w_we;

    assign w_dest  = auto ? r_ptr : s;
    // clear wins over load: a colliding load is dropped entirely
    assign w_write = load & ~clear;

    generate
        for (genvar k = 0; k < 16; k++) begin : g_slot
            assign w_we[k] = w_write & (w_dest == 4'(k));

            // Data survives clear; only reset zeroes it
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_slot[k] <= '0;
                end else if (w_we[k]) begin
                    r_slot[k] <= d;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_valid[k] <= 1'b0;
                end else if (clear) begin
                    r_valid[k] <= 1'b0;
                end else if (w_we[k]) begin
                    r_valid[k] <= 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr  <= 4'd0;
            r_wrap <= 1'b0;
        end else if (clear) begin
            r_ptr  <= 4'd0;
            r_wrap <= 1'b0;
        end else begin
            // Explicit-mode writes to slot 15 must not pulse wrap
            r_wrap <= w_write & auto & (r_ptr == c_last_slot);
            if (w_write && auto) begin
                r_ptr <= r_ptr + 4'd1;
            end
        end
    end

    assign y0    = r_slot[0];
    assign y1    = r_slot[1];
    assign y2    = r_slot[2];
    assign y3    = r_slot[3];
    assign y4    = r_slot[4];
    assign y5    = r_slot[5];
    assign y6    = r_slot[6];
    assign y7    = r_slot[7];
    assign y8    = r_slot[8];
    assign y9    = r_slot[9];
    assign y10   = r_slot[10];
    assign y11   = r_slot[11];
    assign y12   = r_slot[12];
    assign y13   = r_slot[13];
    assign y14   = r_slot[14];
    assign y15   = r_slot[15];
    assign valid = r_valid;
    assign ptr   = r_ptr;
    assign full  = &r_valid;
    assign wrap  = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_demultiplexer_1_to_16_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_demultiplexer_1_to_16_reg
// Purpose  : Self-checking bench. Two instances (n=8 and n=16) share all
//            control inputs; the 8-bit one sees the low byte of the data.
//            A frame-level reference model tracks the expected contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demultiplexer_1_to_16_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] d;
    logic [3:0]  s;
    logic        load, auto, clear;

    logic [7:0]  y8  [16];
    logic [15:0] y16 [16];
    logic [15:0] valid8, valid16;
    logic [3:0]  ptr8, ptr16;
    logic        full8, full16, wrap8, wrap16;

    always #5 clk = ~clk;

    demultiplexer_1_to_16_reg #(.n(8)) u_dut8 (
        .clk(clk), .rst(rst), .d(d[7:0]), .s(s), .load(load), .auto(auto), .clear(clear),
        .y0(y8[0]), .y1(y8[1]), .y2(y8[2]), .y3(y8[3]), .y4(y8[4]), .y5(y8[5]),
        .y6(y8[6]), .y7(y8[7]), .y8(y8[8]), .y9(y8[9]), .y10(y8[10]), .y11(y8[11]),
        .y12(y8[12]), .y13(y8[13]), .y14(y8[14]), .y15(y8[15]),
        .valid(valid8), .ptr(ptr8), .full(full8), .wrap(wrap8)
    );

    demultiplexer_1_to_16_reg #(.n(16)) u_dut16 (
        .clk(clk), .rst(rst), .d(d), .s(s), .load(load), .auto(auto), .clear(clear),
        .y0(y16[0]), .y1(y16[1]), .y2(y16[2]), .y3(y16[3]), .y4(y16[4]), .y5(y16[5]),
        .y6(y16[6]), .y7(y16[7]), .y8(y16[8]), .y9(y16[9]), .y10(y16[10]), .y11(y16[11]),
        .y12(y16[12]), .y13(y16[13]), .y14(y16[14]), .y15(y16[15]),
        .valid(valid16), .ptr(ptr16), .full(full16), .wrap(wrap16)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: frame as an array of words plus a written-flag per slot
    logic [15:0] m_y [16];
    bit          m_v [16];
    int          m_p;
    bit          m_w;

    function automatic logic [15:0] m_valid();
        logic [15:0] v = '0;
        for (int k = 0; k < 16; k++) v[k] = m_v[k];
        return v;
    endfunction

    function automatic bit m_full();
        for (int k = 0; k < 16; k++) if (!m_v[k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 16; k++) begin m_y[k] = '0; m_v[k] = 1'b0; end
        m_p = 0; m_w = 1'b0;
    endtask

    task automatic model_step(input bit ld, input bit au, input bit cl,
                              input int sel, input logic [15:0] dat);
        int dst;
        if (cl) begin
            for (int k = 0; k < 16; k++) m_v[k] = 1'b0;
            m_p = 0; m_w = 1'b0;
        end else if (ld) begin
            dst = au ? m_p : sel;
            m_y[dst] = dat;
            m_v[dst] = 1'b1;
            m_w = au && (m_p == 15);
            if (au) m_p = (m_p + 1) % 16;
        end else begin
            m_w = 1'b0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " valid16"}, 32'(valid16), 32'(m_valid()));
        chk({tag, " valid8"},  32'(valid8),  32'(m_valid()));
        chk({tag, " ptr16"},   32'(ptr16),   32'(m_p));
        chk({tag, " ptr8"},    32'(ptr8),    32'(m_p));
        chk({tag, " full"},    {30'd0, full8, full16}, {30'd0, m_full(), m_full()});
        chk({tag, " wrap"},    {30'd0, wrap8, wrap16}, {30'd0, m_w, m_w});
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("%s y16[%0d]", tag, k), 32'(y16[k]), 32'(m_y[k]));
            chk($sformatf("%s y8[%0d]", tag, k),  32'(y8[k]),  32'(m_y[k][7:0]));
        end
    endtask

    // Drive one cycle; returns at posedge+1 with outputs settled
    task automatic apply(input bit ld, input bit au, input bit cl,
                         input logic [3:0] sel, input logic [15:0] dat);
        load = ld; auto = au; clear = cl; s = sel; d = dat;
        @(posedge clk);
        model_step(ld, au, cl, int'(sel), dat);
        #1;
    endtask

    typedef struct {
        bit          ld, au, cl;
        logic [3:0]  s;
        logic [15:0] d;
        logic [15:0] ev;
        logic [3:0]  ep;
        bit          ew, ef;
        int          slot;
        logic [15:0] ey;
    } vec_t;

    vec_t tbl [$];

    initial begin
        vec_t v;
        logic [15:0] acc;
        logic [15:0] y5_before;
        int          idx;

        // Directed frame sequence with hand-derived expectations
        tbl.push_back('{1, 0, 0, 4'd9, 16'h00A5, 16'h0200, 4'd0, 0, 0, 9, 16'h00A5});
        acc = 16'h0200;
        for (int k = 0; k < 16; k++) begin
            acc[k] = 1'b1;
            v = '{1, 1, 0, 4'd0, 16'(16'h10 + k), acc, 4'((k + 1) % 16),
                  (k == 15), (k == 15), k, 16'(16'h10 + k)};
            tbl.push_back(v);
        end
        tbl.push_back('{1, 1, 0, 4'd0,  16'h00EE, 16'hFFFF, 4'd1, 0, 1, 0,  16'h00EE});
        tbl.push_back('{0, 1, 0, 4'd7,  16'h1234, 16'hFFFF, 4'd1, 0, 1, 7,  16'h0017});
        tbl.push_back('{1, 0, 0, 4'd15, 16'h0055, 16'hFFFF, 4'd1, 0, 1, 15, 16'h0055});

        rst = 1'b1; load = 0; auto = 0; clear = 0; s = '0; d = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid", 32'(valid16), 32'h0);
        chk("reset ptr",   32'(ptr16),   32'h0);
        chk("reset full",  {31'd0, full16}, 32'h0);
        check_model("reset");
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].ld, tbl[i].au, tbl[i].cl, tbl[i].s, tbl[i].d);
            chk($sformatf("vec%0d valid", i), 32'(valid16), 32'(tbl[i].ev));
            chk($sformatf("vec%0d ptr", i),   32'(ptr16),   32'(tbl[i].ep));
            chk($sformatf("vec%0d wrap", i),  {30'd0, wrap8, wrap16}, {30'd0, tbl[i].ew, tbl[i].ew});
            chk($sformatf("vec%0d full", i),  {30'd0, full8, full16}, {30'd0, tbl[i].ef, tbl[i].ef});
            chk($sformatf("vec%0d y16", i),   32'(y16[tbl[i].slot]), 32'(tbl[i].ey));
            chk($sformatf("vec%0d y8", i),    32'(y8[tbl[i].slot]),  32'(tbl[i].ey[7:0]));
            check_model($sformatf("vec%0d", i));
        end

        // Clear collision: partial auto fill to ptr=5, then clear+load together
        apply(0, 0, 1, 4'd0, 16'h0);
        for (int k = 0; k < 5; k++) apply(1, 1, 0, 4'd0, 16'(16'h30 + k));
        chk("partial ptr", 32'(ptr16), 32'd5);
        y5_before = y16[5];
        chk("y5 pre-clear", 32'(y5_before), 32'h0015);
        apply(1, 1, 1, 4'd0, 16'h0077);
        chk("coll valid", 32'(valid16), 32'h0);
        chk("coll ptr",   32'(ptr16),   32'h0);
        chk("coll full",  {31'd0, full16}, 32'h0);
        chk("coll y5",    32'(y16[5]),  32'h0015);
        idx = -1;
        for (int k = 0; k < 16; k++) if (y16[k] == 16'h0077 || y8[k] == 8'h77) idx = k;
        chk("coll no 77 slot", 32'(idx), 32'hFFFF_FFFF);
        check_model("coll");

        // Mode mix: explicit writes must not move the pointer
        apply(1, 0, 0, 4'd3, 16'hBEEF);
        chk("mix ptr0", 32'(ptr16), 32'd0);
        apply(1, 1, 0, 4'd3, 16'h1111);
        apply(1, 1, 0, 4'd3, 16'h2222);
        chk("mix ptr2", 32'(ptr16), 32'd2);
        apply(1, 0, 0, 4'd12, 16'h3333);
        chk("mix ptr hold", 32'(ptr16), 32'd2);
        chk("mix y3",  32'(y16[3]), 32'hBEEF);
        chk("mix y0",  32'(y16[0]), 32'h1111);
        chk("mix y1",  32'(y16[1]), 32'h2222);
        chk("mix y8_3", 32'(y8[3]), 32'h00EF);
        check_model("mix");

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            apply($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 31) == 0, 4'($urandom), 16'($urandom));
            check_model($sformatf("rnd%0d", i));
        end

        // Asynchronous reset mid-cycle, checked before any clock edge
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async valid", 32'(valid16), 32'h0);
        chk("async ptr",   32'(ptr16),   32'h0);
        chk("async full",  {30'd0, full8, full16}, 32'h0);
        chk("async wrap",  {30'd0, wrap8, wrap16}, 32'h0);
        check_model("async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(1, 1, 0, 4'd0, 16'h00C3);
        check_model("post-reset");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
